// File: rtl/gen_scheduler.sv
// gen_scheduler: sequences grid generations for an 8-row life grid.
// Waits on a tick-based period (or a manual step while paused), then
// sweeps all 8 rows through next-state logic or writes the seed pattern,
// and finishes each sequence with a one-cycle commit to the LED shadow.
// Every output is a flop loaded from the next-state decode.
module gen_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       SW_pause,
    input  logic       tick,
    input  logic [3:0] period,
    input  logic       step_req,
    input  logic       load_req,
    output logic [2:0] row_idx,
    output logic       row_we,
    output logic       seed_sel,
    output logic       commit,
    output logic       busy,
    output logic [7:0] gen_count
);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_PAUSED = 3'd1,
        ST_SWEEP  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] tick_cnt, tick_cnt_nxt;
    logic [3:0] tick_limit;
    logic       last_row;

    logic [2:0] row_idx_d;
    logic       row_we_d, seed_sel_d, commit_d, busy_d;
    logic [7:0] gen_count_d;

    // period 0 behaves like period 1; compare against the last tick index
    assign tick_limit = (period == 4'd0) ? 4'd0 : period - 4'd1;
    // row_idx doubles as the row counter while sweeping/loading
    assign last_row   = (row_idx == 3'd7);

    // State and tick counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_WAIT;
            tick_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
        end
    end

    // Next-state: load beats everything, pause beats tick expiry in WAIT,
    // and releasing the pause switch beats a step request in PAUSED
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        case (state)
            ST_WAIT: begin
                if (load_req) begin
                    state_nxt = ST_LOAD;
                end else if (SW_pause) begin
                    state_nxt = ST_PAUSED;
                end else if (tick) begin
                    // >= so a shortened period fires on the very next tick
                    if (tick_cnt >= tick_limit) begin
                        state_nxt    = ST_SWEEP;
                        tick_cnt_nxt = 4'd0;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            ST_PAUSED: begin
                if (load_req)
                    state_nxt = ST_LOAD;
                else if (!SW_pause)
                    state_nxt = ST_WAIT;
                else if (step_req)
                    state_nxt = ST_SWEEP;
            end
            ST_SWEEP, ST_LOAD: begin
                if (last_row)
                    state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_nxt = SW_pause ? ST_PAUSED : ST_WAIT;
            end
            default: begin
                state_nxt = ST_WAIT;
            end
        endcase
    end

    // Output decode from the upcoming state, loaded into the output flops
    always_comb begin
        row_idx_d   = 3'd0;
        row_we_d    = 1'b0;
        seed_sel_d  = 1'b0;
        commit_d    = 1'b0;
        busy_d      = 1'b0;
        gen_count_d = gen_count;
        case (state_nxt)
            ST_SWEEP, ST_LOAD: begin
                row_we_d   = 1'b1;
                busy_d     = 1'b1;
                seed_sel_d = (state_nxt == ST_LOAD);
                // a sequence never re-enters itself, so same state = next row
                row_idx_d  = (state == state_nxt) ? row_idx + 3'd1 : 3'd0;
            end
            ST_COMMIT: begin
                commit_d    = 1'b1;
                busy_d      = 1'b1;
                gen_count_d = (state == ST_LOAD) ? 8'd0 : gen_count + 8'd1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx   <= 3'd0;
            row_we    <= 1'b0;
            seed_sel  <= 1'b0;
            commit    <= 1'b0;
            busy      <= 1'b0;
            gen_count <= 8'd0;
        end else begin
            row_idx   <= row_idx_d;
            row_we    <= row_we_d;
            seed_sel  <= seed_sel_d;
            commit    <= commit_d;
            busy      <= busy_d;
            gen_count <= gen_count_d;
        end
    end

endmodule
